// File: rtl/layer2_flatten_tx_if.sv
// Handshake bundle between the pooled-feature producer, the flatten/transpose
// block and the FC1 feature consumer.
interface layer2_flatten_tx_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32
);
  logic                           in_valid;
  logic [DATA_W-1:0]              in_data;
  logic                           in_ready;
  logic [NUM_CH-1:0][DATA_W-1:0]  out_ch;
  logic                           out_valid;
  logic                           out_ready;
  logic                           frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_ch, out_valid, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_ch, out_valid, frame_done
  );
endinterface

// File: rtl/layer2_flatten_tx.sv
// Flatten/transpose transmitter: ingests 256 channel-major features into a
// ping-pong frame buffer and emits each frame as 16 beats of 16 channels.

module layer2_flatten_lane #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic              sel,
  input  logic              en,
  output logic [DATA_W-1:0] q
);
  always_comb begin
    q = '0;
    if (en) q = sel ? w1 : w0;
  end
endmodule

module layer2_flatten_tx #(
  parameter int NUM_CH  = 16,
  parameter int SAMPLES = 16,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  layer2_flatten_tx_if.slave   bus
);
  localparam int FRAME = NUM_CH * SAMPLES;
  localparam int AW    = $clog2(FRAME);
  localparam int BW    = $clog2(SAMPLES);

  logic [DATA_W-1:0] bank_q [2][FRAME];

  logic [1:0]    full_q,  full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [BW-1:0] beat_q,    beat_d;
  logic          frame_done_q, frame_done_d;

  logic in_ready, out_valid, in_xfer, out_xfer;
  logic wr_last, rd_last;

  assign in_ready  = !rst && !full_q[wr_bank_q];
  assign out_valid = !rst && full_q[rd_bank_q];
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;
  assign wr_last   = (wr_cnt_q == AW'(FRAME - 1));
  assign rd_last   = (beat_q == BW'(SAMPLES - 1));

  // Set and clear of full can't hit the same bank in one cycle: set needs the
  // write bank empty, clear needs the read bank full.
  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    rd_bank_d    = rd_bank_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;
    if (in_xfer) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (out_xfer) begin
      beat_d = beat_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        frame_done_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_bank_q    <= rd_bank_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame storage carries no reset; a frame is only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (in_xfer) bank_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    localparam logic [AW-1:0] BASE = AW'(c * SAMPLES);
    logic [AW-1:0] idx;
    assign idx = BASE + {{(AW-BW){1'b0}}, beat_q};
    layer2_flatten_lane #(.DATA_W(DATA_W)) u_lane (
      .w0  (bank_q[0][idx]),
      .w1  (bank_q[1][idx]),
      .sel (rd_bank_q),
      .en  (out_valid),
      .q   (bus.out_ch[c])
    );
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.frame_done = frame_done_q && !rst;
endmodule

// File: tb/tb_layer2_flatten_tx.sv
// Bench for layer2_flatten_tx: table of frame scenarios plus directed
// ping-pong, latency and mid-frame reset sequences, checked by a scoreboard.
module tb_layer2_flatten_tx;
  localparam int NC = 16, NS = 16, DW = 32, FR = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer2_flatten_tx_if #(.NUM_CH(NC), .DATA_W(DW)) bus();
  layer2_flatten_tx #(.NUM_CH(NC), .SAMPLES(NS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int nfr; int base0; int base1; int vprob; bit toggle;
    int st_beat; int st_len;
    int exp_beats; int exp_done; int exp_b3_0; int exp_b3_15;
  } vec_t;
  vec_t tv[4];

  // scoreboard: every accepted word in order; the front 256 are the frame on air
  logic [DW-1:0] expw[$];
  int mon_beat = 0, beats_seen = 0, dones_seen = 0;
  bit exp_done = 0, hold_pend = 0;
  logic [DW-1:0] b3_0 = '0, b3_15 = '0;
  logic [NC-1:0][DW-1:0] hold_ch;

  always @(negedge clk) begin
    int bc;
    if (rst) begin
      chk("rst_outputs", bus.out_valid == 0 && bus.in_ready == 0 && bus.frame_done == 0 && bus.out_ch == '0,
          {bus.out_valid, bus.in_ready, bus.frame_done}, 0);
      expw.delete(); mon_beat = 0; exp_done = 0; hold_pend = 0;
    end else begin
      chk("frame_done", bus.frame_done == exp_done, bus.frame_done, exp_done);
      if (bus.frame_done) dones_seen++;
      exp_done = 0;
      if (hold_pend) chk("stall_hold", bus.out_valid && bus.out_ch == hold_ch, bus.out_valid, 1);
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_ch   = bus.out_ch;
      if (bus.out_valid && bus.out_ready) begin
        if (expw.size() < FR) chk("stale_beat", 0, expw.size(), FR);
        else begin
          bc = -1;
          for (int c = 0; c < NC; c++)
            if (bc < 0 && bus.out_ch[c] !== expw[c*NS+mon_beat]) bc = c;
          if (bc < 0) chk("beat_data", 1, 0, 0);
          else chk($sformatf("beat%0d_ch%0d", mon_beat, bc), 0, bus.out_ch[bc], expw[bc*NS+mon_beat]);
          if (mon_beat == 3) begin b3_0 = bus.out_ch[0]; b3_15 = bus.out_ch[NC-1]; end
        end
        beats_seen++;
        if (mon_beat == NS-1) begin
          exp_done = 1;
          mon_beat = 0;
          for (int k = 0; k < FR && expw.size() > 0; k++) void'(expw.pop_front());
        end else mon_beat++;
      end
      if (bus.in_valid && bus.in_ready) expw.push_back(bus.in_data);
    end
  end

  task automatic send(input int base, input int n, input int vprob);
    int i = 0, guard = 0;
    while (i < n && guard < 20000) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 99) < vprob);
      bus.in_data  = DW'(base + i);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      guard++;
    end
    chk("send_done", i == n, i, n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int sb, sd, st, guard;
    sb = beats_seen; sd = dones_seen; st = 0; guard = 0;
    fork
      begin
        send(v.base0, FR, v.vprob);
        if (v.nfr > 1) send(v.base1, FR, v.vprob);
      end
      begin
        while (beats_seen - sb < v.exp_beats && guard < 5000) begin
          @(posedge clk); #1;
          if (v.st_len > 0 && st < v.st_len && mon_beat == v.st_beat && bus.out_valid) begin
            bus.out_ready = 1'b0; st++;
          end else bus.out_ready = v.toggle ? guard[0] : 1'b1;
          guard++;
        end
      end
    join
    @(posedge clk); #1; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_beats", id), beats_seen - sb == v.exp_beats, beats_seen - sb, v.exp_beats);
    chk($sformatf("v%0d_dones", id), dones_seen - sd == v.exp_done, dones_seen - sd, v.exp_done);
    chk($sformatf("v%0d_b3_ch0", id), b3_0 == DW'(v.exp_b3_0), b3_0, v.exp_b3_0);
    chk($sformatf("v%0d_b3_ch15", id), b3_15 == DW'(v.exp_b3_15), b3_15, v.exp_b3_15);
    chk($sformatf("v%0d_idle", id), !bus.out_valid && bus.in_ready, {bus.out_valid, bus.in_ready}, 1);
  endtask

  initial begin
    int sb, sd;
    //          nfr base0  base1 vprob tog stb stl beats done b3_0  b3_15
    tv[0] = '{1,     0,     0, 100, 0,  0,  0,  16,  1,    3,  243};
    tv[1] = '{1,  4096,     0, 100, 0,  7,  5,  16,  1, 4099, 4339};
    tv[2] = '{1,  1000,     0,  50, 0,  0,  0,  16,  1, 1003, 1243};
    tv[3] = '{2,  5000,  1000, 100, 1,  0,  0,  32,  2, 1003, 1243};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready == 1, bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid == 0, bus.out_valid, 0);

    for (int i = 0; i < 4; i++) run_vec(i, tv[i]);

    // ping-pong: fill both banks with the consumer stalled
    bus.out_ready = 1'b0;
    sb = beats_seen; sd = dones_seen;
    send(2000, FR, 100);
    @(negedge clk);
    chk("latency_out_valid", bus.out_valid == 1, bus.out_valid, 1);
    chk("pp_bank1_free", bus.in_ready == 1, bus.in_ready, 1);
    send(2256, FR, 100);
    @(negedge clk);
    chk("pp_both_full", bus.in_ready == 0, bus.in_ready, 0);
    repeat (4) begin
      @(negedge clk);
      chk("pp_still_full", bus.in_ready == 0, bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      chk("pp_blocked", bus.in_ready == 0, bus.in_ready, 0);
    end
    @(negedge clk);
    chk("pp_resume", bus.in_ready == 1, bus.in_ready, 1);
    chk("pp_frame_b_valid", bus.out_valid == 1, bus.out_valid, 1);
    repeat (20) @(negedge clk);
    chk("pp_beats", beats_seen - sb == 32, beats_seen - sb, 32);
    chk("pp_dones", dones_seen - sd == 2, dones_seen - sd, 2);
    chk("pp_b3_ch0", b3_0 == 2259, b3_0, 2259);
    chk("pp_b3_ch15", b3_15 == 2499, b3_15, 2499);

    // reset in the middle of ingest, then a fresh frame
    send(7000, 100, 100);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid == 0, bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready == 1, bus.in_ready, 1);
    sb = beats_seen; sd = dones_seen;
    send(8000, FR, 100);
    repeat (25) @(negedge clk);
    chk("midrst_beats", beats_seen - sb == 16, beats_seen - sb, 16);
    chk("midrst_dones", dones_seen - sd == 1, dones_seen - sd, 1);
    chk("midrst_b3_ch0", b3_0 == 8003, b3_0, 8003);
    chk("midrst_b3_ch15", b3_15 == 8243, b3_15, 8243);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/layer2_flatten_tx.md
# layer2_flatten_tx

Flatten/transpose transmitter feeding the FC1 stage's 16-channel feature input. It accepts a serial stream of 256 pooled features in channel-major order, buffers them in a ping-pong pair of frame banks, and transmits each frame as 16 parallel beats. In beat s, output channel c carries feature c*16+s. Ingest of frame N+1 overlaps transmission of frame N.

## Interface
- NUM_CH, default 16: parallel output channels. The design is fixed at 16; the parameter exists for checking only.
- SAMPLES, default 16: beats per frame. Frame size = NUM_CH*SAMPLES = 256.
- DATA_W, default 32: feature width.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a feature on in_data.
- in_data  in  DATA_W  feature, channel-major: word n is channel n[7:4], sample n[3:0].
- in_ready  out  1  block can accept in_data this cycle.
- out_ch0 … out_ch15  out  DATA_W each  beat payload; out_chC = feature C*16+beat.
- out_valid  out  1  a beat is presented.
- out_ready  in  1  consumer accepts the beat. Integration drives it high only while layer3_fc1 is in its load state with weights ready.
- frame_done  out  1  one-cycle pulse after the 16th beat of a frame is accepted.

## Operation
- Storage: two banks of 256 x DATA_W (bank0, bank1). Each bank has a flag full[b].
- Pointers:
  - wr_bank (1b) and wr_cnt (8b) for ingest.
  - rd_bank (1b) and beat (4b) for transmit.
- Ingest handshake:
  - in_ready = !rst && !full[wr_bank] (combinational on registered state).
  - A word transfers when in_valid && in_ready. It is written to bank[wr_bank][wr_cnt], then wr_cnt increments.
  - On the transfer with wr_cnt==255: full[wr_bank] is set, wr_cnt wraps to 0, and wr_bank toggles.
- Transmit handshake:
  - out_valid = full[rd_bank].
  - While out_valid is high, out_chC = bank[rd_bank][C*16+beat]. While out_valid is low, all out_chC = 0.
  - A beat transfers when out_valid && out_ready, then beat increments.
  - On the transfer with beat==15: full[rd_bank] is cleared, beat wraps to 0, rd_bank toggles, and frame_done pulses on the next cycle.
- Stall: with out_valid high and out_ready low, beat and all out_ch outputs hold exactly. out_valid never drops without a handshake.
- Simultaneous events:
  - Set of full[wr_bank] and clear of full[rd_bank] in the same cycle refer to different banks; both take effect.
  - If wr_bank==rd_bank and that bank is full, in_ready=0. Ingest resumes the cycle after the bank clears.
- Producer backpressure: in_valid gaps are allowed anywhere; wr_cnt holds.
- Arithmetic: data passes through unmodified. No sign extension, saturation or reordering beyond the transpose.
- Reset (including mid-frame or mid-transmit):
  - full[0]=full[1]=0; wr_bank=rd_bank=0; wr_cnt=0; beat=0.
  - Any partial or buffered frame is discarded; bank contents need not be cleared.
  - Output values while rst is high: out_valid=0, in_ready=0, frame_done=0, out_ch*=0.

## Timing
- Input throughput: 1 word/cycle while in_ready is high.
- Output throughput: 1 beat/cycle while out_ready is high.
- Latency: 256th word accepted at edge T → out_valid high in the cycle after T (full register). Beat 0 can then transfer at edge T+1.
- Frame timing: the last beat accepted at edge E → frame_done high for exactly the cycle after E, and that bank is writable (in_ready) from the same cycle.
- Steady state with both sides always ready: a frame ingests in 256 cycles and transmits in 16 cycles. in_ready never drops because at most one bank is ever full.
- First cycle after rst deasserts: in_ready=1, out_valid=0.

## Test plan
- Single frame, in_data=n for n=0..255, out_ready=1: exactly 16 beats. Beat s has out_chC=C*16+s (beat 3: out_ch0=3, out_ch15=243). frame_done pulses once, one cycle after beat 15.
- Consumer stall: out_ready=0 for 5 cycles at beat 7 → out_ch* hold frame values for beat 7, out_valid stays 1, beat 7 is delivered exactly once.
- Ping-pong: out_ready=0 and 512 words sent → in_ready drops after word 511 (both banks full). Releasing out_ready drains frame A then frame B in order; in_ready returns the cycle after A's 16th beat.
- Overlap: frame B streamed while frame A transmits with out_ready toggling 1/0 → B data uncorrupted (B word n = 1000+n checks at out_chC = 1000+C*16+s).
- Reset mid-frame: rst after 100 words of a frame, then a fresh 256-word frame → output matches only the fresh frame. No stale beat; out_valid=0 during reset.
- In-valid gaps: random 50% in_valid with out_ready=1 → bit-exact transpose, wr_cnt never skips or duplicates.
